mmio_console: RTL and testbench

MMIO_CONSOLE -- requirements
Module: mmio_console

---
 rtl/mmio_console.sv | 115 +++++++++++
 tb/tb_mmio_console.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped 8N1 console transmitter with TX FIFO, status and sticky halt flag.
//   clk         : sole clock, rising edge
//   resetn      : asynchronous active-low reset
//   address     : byte address from the core; window is BASE..BASE+15
//   data_in     : write data from the core
//   data_out    : registered read data, 0 on unselected or write cycles
//   byte_enable : write lane enables
//   we          : 1 = write, 0 = read
//   tx          : serial line, 8N1, idle high
//   halt        : sticky program-finished flag
module mmio_console #(
  parameter logic [31:0] BASE    = 32'h800,
  parameter int          CLK_DIV = 4,
  parameter int          DEPTH   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [3:0]  byte_enable,
  input  logic        we,
  output logic        tx,
  output logic        halt
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [15:0] baud, baud_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic overflow, sel, push, pop, full, empty, busy, accept, wr_sel;
  logic [1:0] off;
  logic [31:0] rdata;
  logic unused_addr;
  assign unused_addr = ^address[1:0];
  assign sel = address[31:4] == BASE[31:4];
  assign off = address[3:2];
  assign wr_sel = sel && we;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign busy = state != IDLE;
  assign pop = state == IDLE && !empty;
  assign push = wr_sel && off == 2'd0 && byte_enable[0];
  // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign accept = push && (!full || pop);
  assign rdata = off == 2'd1 ? {24'b0, overflow, busy, full, empty, 4'(count)} :
                 off == 2'd2 ? {31'b0, halt} : '0;
  assign tx = !(state == START || (state == DATA && !shreg[0]));
  always_ff @(posedge clk) begin
    if (accept) mem[wp] <= data_in[7:0];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      halt <= 1'b0;
      data_out <= '0;
    end else begin
      wp <= accept ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
      if (push && full && !pop) overflow <= 1'b1;
      else if (wr_sel && off == 2'd1 && byte_enable[0] && data_in[7]) overflow <= 1'b0;
      if (wr_sel && off == 2'd2 && |byte_enable && |data_in) halt <= 1'b1;
      data_out <= (sel && !we) ? rdata : '0;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      baud <= '0;
      bitcnt <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bitcnt <= bitcnt_n;
      shreg <= shreg_n;
    end
  end
  always_comb begin
    state_n = state;
    baud_n = baud == '0 ? RELOAD : baud - 16'd1;
    bitcnt_n = bitcnt;
    shreg_n = shreg;
    unique case (state)
      IDLE: begin
        baud_n = baud;
        if (!empty) begin
          state_n = START;
          baud_n = RELOAD;
          shreg_n = mem[rp];
        end
      end
      START: if (baud == '0) begin
        state_n = DATA;
        bitcnt_n = '0;
      end
      DATA: if (baud == '0) begin
        shreg_n = {1'b0, shreg[7:1]};
        bitcnt_n = bitcnt + 3'd1;
        state_n = bitcnt == 3'd7 ? STOP : DATA;
      end
      STOP: state_n = baud == '0 ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: randomized scoreboard bench for mmio_console against a queue-based reference model.
module tb_mmio_console;
  localparam logic [31:0] BASE = 32'h800;
  localparam int D = 4;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [31:0] address = '0, data_in = '0, data_out;
  logic [3:0] byte_enable = '0;
  logic we = 1'b0;
  logic tx, halt;
  mmio_console #(.BASE(BASE), .CLK_DIV(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .address(address), .data_in(data_in), .data_out(data_out),
    .byte_enable(byte_enable), .we(we), .tx(tx), .halt(halt)
  );
  always #5 clk = ~clk;
  typedef struct {int e; bit chk; logic [31:0] d; bit h;} exp_t;
  exp_t sb[$];
  logic [7:0] mq[$];
  logic [7:0] txq[$];
  int free_at = 0;
  bit m_ovf = 1'b0, m_halt = 1'b0;
  int tests = 0, fails = 0;
  int n_edge = 0;
  always @(posedge clk) n_edge++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, n_edge);
    end
  endtask
  // One bus cycle: the model decides what the coming edge must do, then the edge happens.
  // A byte leaves the FIFO at the first edge where it is non-empty and the line has been
  // free since the previous frame ended (frame 10*D cycles plus one idle cycle).
  task automatic op(input bit w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    int e, cnt;
    bit sel, pop, busy;
    logic [1:0] off;
    logic [31:0] rd;
    logic [7:0] tmp;
    exp_t x;
    e = n_edge + 1;
    sel = a[31:4] == BASE[31:4];
    off = a[3:2];
    cnt = mq.size();
    busy = e < free_at;
    pop = cnt > 0 && e >= free_at;
    rd = off == 2'd1 ? {24'b0, m_ovf, busy, cnt == DEPTH, cnt == 0, 4'(cnt)} :
         off == 2'd2 ? {31'b0, m_halt} : 32'b0;
    if (pop) begin
      tmp = mq.pop_front();
      free_at = e + 10 * D + 1;
    end
    if (sel && w && off == 2'd0 && be[0]) begin
      if (cnt < DEPTH || pop) begin
        mq.push_back(d[7:0]);
        txq.push_back(d[7:0]);
      end else m_ovf = 1'b1;
    end
    if (sel && w && off == 2'd1 && be[0] && d[7]) m_ovf = 1'b0;
    if (sel && w && off == 2'd2 && be != 0 && d != 0) m_halt = 1'b1;
    x.e = e;
    x.chk = !(sel && w);
    x.d = (sel && !w) ? rd : 32'b0;
    x.h = m_halt;
    sb.push_back(x);
    address = a;
    data_in = d;
    byte_enable = be;
    we = w;
    @(posedge clk);
    #1;
  endtask
  task automatic rand_op();
    int k;
    logic [31:0] base, d;
    logic [3:0] be;
    k = $urandom_range(0, 99);
    base = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) == 1 ? 32'h900 : 32'h7F0) : BASE;
    d = $urandom;
    be = 4'($urandom) | 4'($urandom_range(0, 4) != 0);
    if (k < 45) op(1'b1, base, be, d);
    else if (k < 65) op(1'b0, base + 32'h4, 4'($urandom), d);
    else if (k < 72) op(1'b1, base + 32'h4, be, d);
    else if (k < 75) op(1'b1, base + 32'h8, 4'($urandom), $urandom_range(0, 1) == 1 ? 32'b0 : d);
    else if (k < 82) op(1'b0, base + 32'(4 * $urandom_range(0, 3)), be, d);
    else if (k < 86) op(1'b1, base + 32'hC, be, d);
    else op(1'b0, 32'h0, 4'b0, d);
  endtask
  task automatic drain();
    int b = 0;
    while ((mq.size() > 0 || txq.size() > 0 || n_edge + 1 < free_at + 2) && b < 3000) begin
      op(1'b0, BASE + 32'h4, 4'b0, 32'b0);
      b++;
    end
    tests++;
    if (b >= 3000) begin
      fails++;
      $display("FAIL drain: %0d bytes still expected after %0d cycles", txq.size(), b);
    end
  endtask
  exp_t mon_x;
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].e == n_edge) begin
      mon_x = sb.pop_front();
      if (mon_x.chk) check("data_out", data_out, mon_x.d);
      check("halt", {31'b0, halt}, {31'b0, mon_x.h});
    end
  end
  // Serial receiver: samples the middle of each bit cell counted from the start edge.
  int sm_cnt = 0;
  bit sm_act = 1'b0;
  logic [7:0] sm_b = '0;
  always @(negedge clk) begin
    if (!resetn) sm_act = 1'b0;
    else if (!sm_act) begin
      if (tx === 1'b0) begin
        sm_act = 1'b1;
        sm_cnt = 1;
        sm_b = '0;
      end
    end else begin
      sm_cnt++;
      if (sm_cnt == D / 2 + 1) check("start_bit", {31'b0, tx}, 32'b0);
      for (int i = 0; i < 8; i++) if (sm_cnt == D * (i + 1) + D / 2 + 1) sm_b[i] = tx;
      if (sm_cnt == 9 * D + D / 2 + 1) begin
        check("stop_bit", {31'b0, tx}, 32'b1);
        if (txq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_byte: got unexpected frame %h expected none", sm_b);
        end else check("tx_byte", {24'b0, sm_b}, {24'b0, txq.pop_front()});
        sm_act = 1'b0;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    #1;
    check("reset_tx", {31'b0, tx}, 32'b1);
    check("reset_halt", {31'b0, halt}, 32'b0);
    check("reset_data_out", data_out, 32'b0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    op(1'b0, BASE + 32'h4, 4'b0, 32'b0);
    op(1'b1, BASE, 4'b0001, 32'h41);
    repeat (3) op(1'b0, BASE + 32'h4, 4'b0, 32'b0);
    drain();
    for (int i = 0; i < 10; i++) op(1'b1, BASE, 4'b0001, 32'h30 + 32'(i));
    op(1'b0, BASE + 32'h4, 4'b0, 32'b0);
    op(1'b1, BASE + 32'h4, 4'b0001, 32'h80);
    op(1'b0, BASE + 32'h4, 4'b0, 32'b0);
    for (int i = 0; i < 45; i++) op(1'b1, BASE, 4'b0001, 32'h60 + 32'(i));
    op(1'b0, BASE + 32'h4, 4'b0, 32'b0);
    op(1'b1, 32'h900, 4'hF, 32'h1);
    op(1'b1, 32'h7FC, 4'hF, 32'h1);
    op(1'b1, BASE + 32'h8, 4'b0001, 32'h0);
    op(1'b1, BASE + 32'h8, 4'b0001, 32'h1);
    op(1'b1, BASE + 32'h8, 4'b0001, 32'h0);
    op(1'b0, BASE + 32'h8, 4'b0, 32'b0);
    drain();
    repeat (400) rand_op();
    drain();
    op(1'b1, BASE, 4'b0001, 32'h55);
    op(1'b1, BASE, 4'b0001, 32'h11);
    op(1'b1, BASE, 4'b0001, 32'h22);
    op(1'b1, BASE, 4'b0001, 32'h33);
    repeat (14) op(1'b0, 32'h0, 4'b0, 32'b0);
    @(negedge clk);
    #1;
    check("pre_reset_tx_low", {31'b0, tx}, 32'b0);
    resetn = 1'b0;
    #1;
    check("async_reset_tx", {31'b0, tx}, 32'b1);
    check("async_reset_halt", {31'b0, halt}, 32'b0);
    check("async_reset_data_out", data_out, 32'b0);
    mq.delete();
    txq.delete();
    free_at = 0;
    m_ovf = 1'b0;
    m_halt = 1'b0;
    repeat (2) @(negedge clk);
    check("held_reset_tx", {31'b0, tx}, 32'b1);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    repeat (30) op(1'b0, BASE + 32'h4, 4'b0, 32'b0);
    check("post_reset_tx", {31'b0, tx}, 32'b1);
    repeat (200) rand_op();
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
